// File: rtl/dist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dist_pkg
// Description : Shared width derivations and FSM encoding for the Euclidean
//               distance / integer square-root engine.
// Revision    : 1.0 - initial release
// ============================================================================
package dist_pkg;

    // Top-level sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SQRT  = 2'd2,
        ST_DONE  = 2'd3
    } dist_state_t;

    // Ceiling log2; returns 0 for value <= 1
    function automatic int f_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Width of the sum of DIMS squared COORD_W-bit differences
    function automatic int f_sum_w(input int coord_w, input int dims);
        return 2 * coord_w + f_clog2(dims);
    endfunction

    // Root width: half the radicand width, rounded up
    function automatic int f_root_w(input int sum_w);
        return (sum_w + 1) / 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/isqrt_iter.sv
`default_nettype none
// ============================================================================
// Module      : isqrt_iter
// Description : Restoring digit-by-digit integer square root. One root bit
//               per clock, MSB radicand pair first. The start cycle performs
//               the first iteration directly on the incoming radicand, so a
//               full result takes exactly ROOT_W clock edges; done pulses for
//               one cycle once root/rem are final and stay held afterwards.
// Revision    : 1.0 - initial release
// ============================================================================
module isqrt_iter
    import dist_pkg::*;
#(
    parameter int ROOT_W = 11
) (
    input  logic                  distance_clk,
    input  logic                  root_rst,
    input  logic                  start,
    input  logic [2*ROOT_W-1:0]   radicand,
    output logic                  busy,
    output logic                  done,
    output logic [ROOT_W-1:0]     root,
    output logic [ROOT_W:0]       rem
);

    localparam int c_cnt_w = (f_clog2(ROOT_W) > 0) ? f_clog2(ROOT_W) : 1;

    logic [2*ROOT_W-1:0] r_rad;
    logic [ROOT_W-1:0]   r_root;
    logic [ROOT_W:0]     r_rem;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_busy;
    logic                r_done;

    logic [2*ROOT_W-1:0] w_src_rad;
    logic [ROOT_W-1:0]   w_src_root;
    logic [ROOT_W:0]     w_src_rem;
    logic [ROOT_W+2:0]   w_rem_sh;
    logic [ROOT_W+2:0]   w_trial;
    logic                w_ge;
    logic [ROOT_W:0]     w_rem_next;
    logic [ROOT_W-1:0]   w_root_next;
    logic [2*ROOT_W-1:0] w_rad_next;

    // One restoring step; a start cycle begins from rem=0, root=0
    always_comb begin
        w_src_rad   = start ? radicand : r_rad;
        w_src_root  = start ? '0 : r_root;
        w_src_rem   = start ? '0 : r_rem;
        w_rem_sh    = {w_src_rem, w_src_rad[2*ROOT_W-1 -: 2]};
        w_trial     = {1'b0, w_src_root, 2'b01};
        w_ge        = (w_rem_sh >= w_trial);
        // Partial remainder never exceeds 2*root, so ROOT_W+1 bits suffice
        w_rem_next  = w_ge ? (ROOT_W+1)'(w_rem_sh - w_trial) : (ROOT_W+1)'(w_rem_sh);
        w_root_next = (w_src_root << 1) | ROOT_W'(w_ge);
        w_rad_next  = w_src_rad << 2;
    end

    // Iteration registers and progress counter
    always_ff @(posedge distance_clk or negedge root_rst) begin
        if (!root_rst) begin
            r_rad  <= '0;
            r_root <= '0;
            r_rem  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_rad  <= w_rad_next;
                r_root <= w_root_next;
                r_rem  <= w_rem_next;
                r_cnt  <= c_cnt_w'(1);
                r_busy <= (ROOT_W > 1);
                r_done <= (ROOT_W == 1);
            end else if (r_busy) begin
                r_rad  <= w_rad_next;
                r_root <= w_root_next;
                r_rem  <= w_rem_next;
                r_cnt  <= r_cnt + c_cnt_w'(1);
                if (r_cnt == c_cnt_w'(ROOT_W - 1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign root = r_root;
    assign rem  = r_rem;

endmodule
`default_nettype wire

// File: rtl/distance_sqrt_engine.sv
`default_nettype none
// ============================================================================
// Module      : distance_sqrt_engine
// Description : Euclidean distance unit. Accepts a pair of DIMS-axis points,
//               accumulates squared per-axis differences one axis per cycle
//               (square registered, then added), and optionally takes the
//               exact integer square root with remainder.
// Revision    : 1.0 - initial release
// ============================================================================
module distance_sqrt_engine
    import dist_pkg::*;
#(
    parameter  int COORD_W = 10,
    parameter  int DIMS    = 2,
    localparam int SUM_W   = f_sum_w(COORD_W, DIMS),
    localparam int ROOT_W  = f_root_w(SUM_W)
) (
    input  logic                     distance_clk,
    input  logic                     root_rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DIMS*COORD_W-1:0]  in_a,
    input  logic [DIMS*COORD_W-1:0]  in_b,
    input  logic                     in_mode_sq,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SUM_W-1:0]         out_sumsq,
    output logic [ROOT_W-1:0]        out_root,
    output logic [ROOT_W:0]          out_rem
);

    localparam int c_sq_w = 2 * COORD_W;
    localparam int c_ax_w = (f_clog2(DIMS + 1) > 0) ? f_clog2(DIMS + 1) : 1;

    dist_state_t r_state;
    dist_state_t w_state_next;

    logic [DIMS*COORD_W-1:0] r_a;
    logic [DIMS*COORD_W-1:0] r_b;
    logic                    r_mode_sq;
    logic [c_ax_w-1:0]       r_axis;
    logic [c_sq_w-1:0]       r_sq_term;
    logic [SUM_W-1:0]        r_acc;
    logic [SUM_W-1:0]        r_out_sumsq;
    logic [ROOT_W-1:0]       r_out_root;
    logic [ROOT_W:0]         r_out_rem;

    logic [c_sq_w-1:0]       w_axis_sq [DIMS];
    logic [c_sq_w-1:0]       w_sel_sq;
    logic [SUM_W-1:0]        w_acc_next;
    logic                    w_accum_last;
    logic                    w_handshake;
    logic                    w_sqrt_start;
    logic                    w_sqrt_busy;
    logic                    w_sqrt_done;
    logic [ROOT_W-1:0]       w_sqrt_root;
    logic [ROOT_W:0]         w_sqrt_rem;

    // Per-axis absolute difference squared at full width
    for (genvar k = 0; k < DIMS; k++) begin : g_axis
        logic [COORD_W-1:0] w_ak;
        logic [COORD_W-1:0] w_bk;
        logic [COORD_W-1:0] w_dk;
        assign w_ak = r_a[k*COORD_W +: COORD_W];
        assign w_bk = r_b[k*COORD_W +: COORD_W];
        assign w_dk = (w_ak >= w_bk) ? (w_ak - w_bk) : (w_bk - w_ak);
        assign w_axis_sq[k] = c_sq_w'(w_dk) * c_sq_w'(w_dk);
    end

    // Select the current axis; the drain step (axis == DIMS) selects zero
    always_comb begin
        w_sel_sq = '0;
        for (int k = 0; k < DIMS; k++) begin
            if (r_axis == c_ax_w'(k)) begin
                w_sel_sq = w_axis_sq[k];
            end
        end
    end

    assign w_acc_next   = r_acc + SUM_W'(r_sq_term);
    assign w_accum_last = (r_axis == c_ax_w'(DIMS));
    assign w_handshake  = in_valid && in_ready;
    assign w_sqrt_start = (r_state == ST_ACCUM) && w_accum_last && !r_mode_sq;

    isqrt_iter #(
        .ROOT_W (ROOT_W)
    ) u_isqrt (
        .distance_clk (distance_clk),
        .root_rst     (root_rst),
        .start        (w_sqrt_start),
        .radicand     ((2*ROOT_W)'(w_acc_next)),
        .busy         (w_sqrt_busy),
        .done         (w_sqrt_done),
        .root         (w_sqrt_root),
        .rem          (w_sqrt_rem)
    );

    // State register; reset aborts any in-flight operation
    always_ff @(posedge distance_clk or negedge root_rst) begin
        if (!root_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = root_rst;
                if (w_handshake) begin
                    w_state_next = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (w_accum_last) begin
                    w_state_next = r_mode_sq ? ST_DONE : ST_SQRT;
                end
            end
            ST_SQRT: begin
                if (w_sqrt_done && !w_sqrt_busy) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Operand capture and axis-serial accumulation
    always_ff @(posedge distance_clk or negedge root_rst) begin
        if (!root_rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_mode_sq <= 1'b0;
            r_axis    <= '0;
            r_sq_term <= '0;
            r_acc     <= '0;
        end else if (r_state == ST_IDLE) begin
            if (w_handshake) begin
                r_a       <= in_a;
                r_b       <= in_b;
                r_mode_sq <= in_mode_sq;
                r_axis    <= '0;
                r_sq_term <= '0;
                r_acc     <= '0;
            end
        end else if (r_state == ST_ACCUM) begin
            r_acc     <= w_acc_next;
            r_sq_term <= w_sel_sq;
            if (!w_accum_last) begin
                r_axis <= r_axis + c_ax_w'(1);
            end
        end
    end

    // Result registers, loaded on entry to DONE and held until the next result
    always_ff @(posedge distance_clk or negedge root_rst) begin
        if (!root_rst) begin
            r_out_sumsq <= '0;
            r_out_root  <= '0;
            r_out_rem   <= '0;
        end else if ((r_state == ST_ACCUM) && w_accum_last && r_mode_sq) begin
            r_out_sumsq <= w_acc_next;
            r_out_root  <= '0;
            r_out_rem   <= '0;
        end else if ((r_state == ST_SQRT) && w_sqrt_done && !w_sqrt_busy) begin
            r_out_sumsq <= r_acc;
            r_out_root  <= w_sqrt_root;
            r_out_rem   <= w_sqrt_rem;
        end
    end

    assign out_sumsq = r_out_sumsq;
    assign out_root  = r_out_root;
    assign out_rem   = r_out_rem;

endmodule
`default_nettype wire

// File: tb/tb_distance_sqrt_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_distance_sqrt_engine
// Description : Self-checking bench for distance_sqrt_engine with a result
//               scoreboard fed by an independent arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_distance_sqrt_engine;

    localparam int COORD_W = 10;
    localparam int DIMS    = 2;
    localparam int SUM_W   = 21;
    localparam int ROOT_W  = 11;

    typedef struct {
        logic [SUM_W-1:0]  sumsq;
        logic [ROOT_W-1:0] root;
        logic [ROOT_W:0]   rem;
        int                lat;
    } exp_t;

    logic                    distance_clk = 1'b0;
    logic                    root_rst     = 1'b0;
    logic                    in_valid     = 1'b0;
    logic                    in_ready;
    logic [DIMS*COORD_W-1:0] in_a         = '0;
    logic [DIMS*COORD_W-1:0] in_b         = '0;
    logic                    in_mode_sq   = 1'b0;
    logic                    out_valid;
    logic                    out_ready    = 1'b0;
    logic [SUM_W-1:0]        out_sumsq;
    logic [ROOT_W-1:0]       out_root;
    logic [ROOT_W:0]         out_rem;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];

    distance_sqrt_engine #(
        .COORD_W (COORD_W),
        .DIMS    (DIMS)
    ) dut (
        .distance_clk (distance_clk),
        .root_rst     (root_rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_mode_sq   (in_mode_sq),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sumsq    (out_sumsq),
        .out_root     (out_root),
        .out_rem      (out_rem)
    );

    always #5 distance_clk = ~distance_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference: brute-force integer root, unrelated to the digit recurrence
    function automatic exp_t model(input int a0, input int a1, input int b0, input int b1, input bit sq);
        exp_t e;
        int   d0, d1, s, r;
        d0 = (a0 > b0) ? a0 - b0 : b0 - a0;
        d1 = (a1 > b1) ? a1 - b1 : b1 - a1;
        s  = d0 * d0 + d1 * d1;
        r  = 0;
        if (!sq) begin
            while ((r + 1) * (r + 1) <= s) r++;
        end
        e.sumsq = SUM_W'(s);
        e.root  = ROOT_W'(r);
        e.rem   = sq ? '0 : (ROOT_W+1)'(s - r * r);
        e.lat   = sq ? DIMS + 1 : DIMS + ROOT_W + 1;
        return e;
    endfunction

    // Issue one pair, wait for the result, optionally stall, then retire it
    task automatic do_op(input string tag, input int a0, input int a1, input int b0, input int b1,
                         input bit sq, input int hold);
        exp_t e;
        int   n;
        @(negedge distance_clk);
        in_a       = {COORD_W'(a1), COORD_W'(a0)};
        in_b       = {COORD_W'(b1), COORD_W'(b0)};
        in_mode_sq = sq;
        in_valid   = 1'b1;
        chk({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
        sb_q.push_back(model(a0, a1, b0, b1, sq));
        @(posedge distance_clk); #1;
        in_valid   = 1'b0;
        in_a       = DIMS*COORD_W'($urandom);
        in_b       = DIMS*COORD_W'($urandom);
        in_mode_sq = ~sq;
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(posedge distance_clk); #1;
            n++;
        end
        if (sb_q.size() == 0) begin
            chk({tag, ".scoreboard_empty"}, 64'd1, 64'd0);
            return;
        end
        e = sb_q.pop_front();
        chk({tag, ".latency"}, 64'(n), 64'(e.lat));
        chk({tag, ".sumsq"}, 64'(out_sumsq), 64'(e.sumsq));
        chk({tag, ".root"}, 64'(out_root), 64'(e.root));
        chk({tag, ".rem"}, 64'(out_rem), 64'(e.rem));
        chk({tag, ".in_ready_busy"}, 64'(in_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge distance_clk);
            in_valid = 1'b1;
            in_a     = DIMS*COORD_W'($urandom);
            @(posedge distance_clk); #1;
            chk({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
            chk({tag, ".hold_outputs"}, 64'({out_sumsq, out_root, out_rem}),
                64'({e.sumsq, e.root, e.rem}));
            chk({tag, ".hold_in_ready"}, 64'(in_ready), 64'd0);
        end
        @(negedge distance_clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge distance_clk); #1;
        out_ready = 1'b0;
        chk({tag, ".retire_valid"}, 64'(out_valid), 64'd0);
        chk({tag, ".retire_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int  a0, a1, b0, b1;
        bit  seen;

        // Reset state
        #12;
        chk("rst.in_ready", 64'(in_ready), 64'd0);
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.outputs", 64'({out_sumsq, out_root, out_rem}), 64'd0);
        @(negedge distance_clk);
        root_rst = 1'b1;
        #1;
        chk("rst.in_ready_released", 64'(in_ready), 64'd1);
        // out_ready outside DONE must not disturb IDLE
        out_ready = 1'b1;
        @(posedge distance_clk); #1;
        out_ready = 1'b0;
        chk("idle.out_ready_ignored", 64'(out_valid), 64'd0);

        do_op("p34",     3, 4, 0, 0, 1'b0, 0);
        do_op("p7239",   7, 2, 3, 9, 1'b0, 0);
        do_op("p3972",   3, 9, 7, 2, 1'b0, 0);
        do_op("pmax",    0, 0, 1023, 1023, 1'b0, 5);
        do_op("sq7239",  7, 2, 3, 9, 1'b1, 0);
        do_op("sqmax",   1023, 0, 0, 1023, 1'b1, 2);
        do_op("zero",    500, 17, 500, 17, 1'b0, 0);

        for (int i = 0; i < 4; i++) begin
            a0 = $urandom_range(0, 1023);
            a1 = $urandom_range(0, 1023);
            b0 = $urandom_range(0, 1023);
            b1 = $urandom_range(0, 1023);
            do_op("rand", a0, a1, b0, b1, bit'(i % 2), i);
        end

        // Reset in the middle of a root-mode operation
        @(negedge distance_clk);
        in_a       = {COORD_W'(9), COORD_W'(12)};
        in_b       = {COORD_W'(1), COORD_W'(2)};
        in_mode_sq = 1'b0;
        in_valid   = 1'b1;
        sb_q.push_back(model(12, 9, 2, 1, 1'b0));
        @(posedge distance_clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge distance_clk);
        #2;
        root_rst = 1'b0;
        #1;
        void'(sb_q.pop_front());
        chk("midrst.out_valid", 64'(out_valid), 64'd0);
        chk("midrst.outputs", 64'({out_sumsq, out_root, out_rem}), 64'd0);
        chk("midrst.in_ready", 64'(in_ready), 64'd0);
        @(negedge distance_clk);
        root_rst = 1'b1;
        seen = 1'b0;
        repeat (16) begin
            @(posedge distance_clk); #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        chk("midrst.no_stale_valid", 64'(seen), 64'd0);
        do_op("post_rst", 3, 4, 0, 0, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/distance_sqrt_engine.md
# distance_sqrt_engine

Parametrised Euclidean distance unit for the K-means datapath. It accepts two DIMS-dimensional points through a valid/ready handshake and accumulates the squared per-axis differences serially. It then computes the exact integer square root and remainder with an iterative digit-by-digit engine. It supersedes the fixed 2-D subtract/multiply/add/root chain and feeds the cluster-assignment comparator.

## Interface
- COORD_W, 10, unsigned coordinate width per axis
- DIMS, 2, number of axes per point (≥1)
- SUM_W, 2*COORD_W+clog2(DIMS) (derived, not overridable), sum-of-squares width (21 at defaults; for DIMS=1, clog2 term is 0)
- ROOT_W, ceil(SUM_W/2) (derived), root width (11 at defaults)

Ports:
- distance_clk  in  1  clock, all state on rising edge
- root_rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  point pair valid
- in_ready  out  1  engine can accept a pair
- in_a  in  DIMS*COORD_W  point A; axis k at bits [k*COORD_W +: COORD_W]
- in_b  in  DIMS*COORD_W  point B, same packing
- in_mode_sq  in  1  1 = squared distance only, skip the root
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_sumsq  out  SUM_W  Σ(a_k−b_k)²
- out_root  out  ROOT_W  floor(sqrt(out_sumsq)), or 0 in sq mode
- out_rem  out  ROOT_W+1  out_sumsq − out_root², or 0 in sq mode

## Operation
- FSM states: IDLE, ACCUM, SQRT, DONE.
- IDLE: in_ready=1. On in_valid&in_ready:
  - capture in_a, in_b and in_mode_sq;
  - clear the accumulator and axis counter;
  - go to ACCUM.
- ACCUM: each cycle handles one axis k (counter 0..DIMS−1):
  - |d| = max(a_k,b_k) − min(a_k,b_k), unsigned, no wrap;
  - acc += d², computed at full width, so no overflow is possible.
  - After axis DIMS−1:
    - if mode_sq, go to DONE;
    - otherwise go to SQRT with the radicand zero-extended to 2*ROOT_W bits.
- SQRT: restoring digit-by-digit method, one root bit per cycle, ROOT_W cycles, MSB pair first:
  - rem' = (rem<<2)|next2;
  - trial = (root<<2)|1;
  - if rem' ≥ trial: rem = rem' − trial and root = (root<<1)|1;
  - else rem = rem' and root = root<<1.
  - After ROOT_W iterations, go to DONE.
- DONE: out_valid=1; out_sumsq, out_root and out_rem are registered and held stable. On out_ready, go to IDLE.
- in_ready is low in ACCUM, SQRT and DONE. A new input pair is never accepted in the same cycle as the output handshake.
- Input values are sampled only at the handshake. Later changes on in_a/in_b do not affect the result.
- root_rst low in any state:
  - forces IDLE immediately and asynchronously;
  - the in-flight result is discarded;
  - no out_valid pulse is produced for it.

## Timing
- Reset values:
  - in_ready=1 once reset is released. While root_rst is low, in_ready=0.
  - out_valid=0, out_sumsq=0, out_root=0, out_rem=0.
- Handshake at edge T: ACCUM occupies cycles T+1..T+DIMS. SQRT occupies the next ROOT_W cycles.
- Root mode: out_valid rises DIMS+ROOT_W+1 cycles after T (14 at defaults).
- Sq mode: out_valid rises DIMS+1 cycles after T (3 at defaults).
- Throughput: one result per (latency + 1) cycles when out_ready is held high. The extra cycle is the DONE→IDLE return.
- Backpressure: DONE holds indefinitely while out_ready=0. All outputs stay constant.
- out_ready asserted outside DONE is ignored.

## Structure
- Package dist_pkg holds:
  - a clog2 constant function;
  - the SUM_W and ROOT_W derivation functions;
  - the state encoding (IDLE=0, ACCUM=1, SQRT=2, DONE=3).
- Sub-module isqrt_iter (parameter ROOT_W):
  - ports: clock, reset, start, radicand, busy, done, root, rem;
  - the top FSM starts it and waits for done.
- The top module keeps the handshake, the axis-serial accumulator and the output registers.

## Test plan
- a=(3,4), b=(0,0), root mode → at T+14: sumsq=25, root=5, rem=0, in_ready low until the output handshake.
- a=(7,2), b=(3,9) → sumsq=65, root=8, rem=1. Repeat with a and b swapped → identical result.
- a=(0,0), b=(1023,1023) → sumsq=2093058, root=1446, rem=2142. No overflow.
- Pair (7,2),(3,9) with in_mode_sq=1 → out_valid at T+3, sumsq=65, root=0, rem=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → outputs stable, in_valid ignored. Raise out_ready → the next pair is accepted the cycle after return to IDLE.
- Reset mid-operation: assert root_rst low at T+6 of a root-mode op → outputs zero immediately, no stale out_valid. The next pair (3,4),(0,0) yields root=5.
